// File: rtl/wb_stage_if.sv
// MEM->WB instruction bus: valid/ready handshake plus the result sources and load descriptor.
// The master side (MEM stage) drives everything except in_ready.
interface wb_stage_if #(
    parameter int DATA_WIDTH    = 32,
    parameter int ADDRESS_WIDTH = 5
);
    logic                     in_valid;
    logic                     in_ready;
    logic                     in_reg_write;
    logic [ADDRESS_WIDTH-1:0] in_rd;
    logic [1:0]               in_wb_sel;
    logic [DATA_WIDTH-1:0]    in_alu_result;
    logic [DATA_WIDTH-1:0]    in_mem_rdata;
    logic [DATA_WIDTH-1:0]    in_pc_plus4;
    logic [2:0]               in_funct3;
    logic [1:0]               in_addr_lsb;

    modport master (
        output in_valid, in_reg_write, in_rd, in_wb_sel, in_alu_result,
               in_mem_rdata, in_pc_plus4, in_funct3, in_addr_lsb,
        input  in_ready
    );

    modport slave (
        input  in_valid, in_reg_write, in_rd, in_wb_sel, in_alu_result,
               in_mem_rdata, in_pc_plus4, in_funct3, in_addr_lsb,
        output in_ready
    );
endinterface

// File: rtl/wb_stage.sv
// Writeback stage: one-entry register, result/load alignment at capture, 1-cycle latency.
// hold freezes the entry and deasserts in_ready; flush kills it; retirement drives the regfile write.
module wb_stage #(
    parameter int DATA_WIDTH    = 32,
    parameter int ADDRESS_WIDTH = 5
) (
    input  logic                     clk,
    input  logic                     rst,
    wb_stage_if.slave                mem,
    input  logic                     hold,
    input  logic                     flush,
    output logic                     rg_wrt_en,
    output logic [ADDRESS_WIDTH-1:0] rg_wrt_dest,
    output logic [DATA_WIDTH-1:0]    rg_wrt_data,
    output logic                     load_err,
    output logic [31:0]              retire_count
);

    logic                     valid_q;
    logic                     reg_write_q;
    logic                     err_q;
    logic [ADDRESS_WIDTH-1:0] rd_q;
    logic [DATA_WIDTH-1:0]    data_q;
    logic [31:0]              count_q;

    logic [7:0]            ld_byte;
    logic [15:0]           ld_half;
    logic [DATA_WIDTH-1:0] ld_data;
    logic                  ld_err;
    logic                  cap_err;
    logic [DATA_WIDTH-1:0] result;
    logic                  retiring;

    always_comb begin
        ld_byte = mem.in_mem_rdata[8*mem.in_addr_lsb +: 8];
        ld_half = mem.in_addr_lsb[1] ? mem.in_mem_rdata[31:16] : mem.in_mem_rdata[15:0];
        ld_data = '0;
        ld_err  = 1'b0;
        case (mem.in_funct3)
            3'b000: ld_data = {{(DATA_WIDTH-8){ld_byte[7]}}, ld_byte};
            3'b100: ld_data = {{(DATA_WIDTH-8){1'b0}}, ld_byte};
            3'b001: begin
                if (mem.in_addr_lsb[0]) ld_err = 1'b1;
                else ld_data = {{(DATA_WIDTH-16){ld_half[15]}}, ld_half};
            end
            3'b101: begin
                if (mem.in_addr_lsb[0]) ld_err = 1'b1;
                else ld_data = {{(DATA_WIDTH-16){1'b0}}, ld_half};
            end
            3'b010: begin
                if (mem.in_addr_lsb != 2'b00) ld_err = 1'b1;
                else ld_data = mem.in_mem_rdata;
            end
            default: ld_err = 1'b1;
        endcase
    end

    // Load errors only matter when the instruction actually selects load data.
    always_comb begin
        cap_err = 1'b0;
        case (mem.in_wb_sel)
            2'b01: begin
                cap_err = ld_err;
                result  = ld_err ? '0 : ld_data;
            end
            2'b10:   result = mem.in_pc_plus4;
            default: result = mem.in_alu_result;
        endcase
    end

    assign retiring = valid_q && !hold && !flush && !rst;

    always_ff @(posedge clk) begin
        if (rst) begin
            valid_q     <= 1'b0;
            reg_write_q <= 1'b0;
            err_q       <= 1'b0;
            rd_q        <= '0;
            data_q      <= '0;
            count_q     <= '0;
        end else begin
            if (retiring) count_q <= count_q + 32'd1;
            if (flush) begin
                valid_q <= 1'b0;
            end else if (!hold) begin
                valid_q <= mem.in_valid;
                if (mem.in_valid) begin
                    reg_write_q <= mem.in_reg_write;
                    err_q       <= cap_err;
                    rd_q        <= mem.in_rd;
                    data_q      <= result;
                end
            end
        end
    end

    assign mem.in_ready   = !hold;
    assign rg_wrt_en      = retiring && reg_write_q && (rd_q != '0) && !err_q;
    assign load_err       = retiring && err_q;
    assign rg_wrt_dest    = rd_q;
    assign rg_wrt_data    = data_q;
    assign retire_count   = count_q;

endmodule

// File: tb/tb_wb_stage.sv
// Randomized + directed bench for wb_stage with a queue-based scoreboard and abstract reference model.
module tb_wb_stage;

    typedef struct {
        logic        rw;
        logic [4:0]  rd;
        logic [1:0]  sel;
        logic [31:0] alu;
        logic [31:0] mem;
        logic [31:0] pc;
        logic [2:0]  f3;
        logic [1:0]  lsb;
    } ins_t;

    typedef struct {
        logic        en;
        logic        lerr;
        logic        ready;
        logic        chk_cnt;
        logic [31:0] cnt;
        logic        chk_dd;
        logic [4:0]  dest;
        logic [31:0] data;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst;
    logic        hold;
    logic        flush;
    logic        rg_wrt_en;
    logic [4:0]  rg_wrt_dest;
    logic [31:0] rg_wrt_data;
    logic        load_err;
    logic [31:0] retire_count;

    wb_stage_if #(.DATA_WIDTH(32), .ADDRESS_WIDTH(5)) bus ();

    wb_stage #(.DATA_WIDTH(32), .ADDRESS_WIDTH(5)) dut (
        .clk          (clk),
        .rst          (rst),
        .mem          (bus.slave),
        .hold         (hold),
        .flush        (flush),
        .rg_wrt_en    (rg_wrt_en),
        .rg_wrt_dest  (rg_wrt_dest),
        .rg_wrt_data  (rg_wrt_data),
        .load_err     (load_err),
        .retire_count (retire_count)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    exp_t exp_q[$];

    // Reference model: the stage holds at most one pending instruction.
    logic        m_present = 1'b0;
    logic        m_rw      = 1'b0;
    logic        m_err     = 1'b0;
    logic [4:0]  m_rd      = '0;
    logic [31:0] m_data    = '0;
    logic [31:0] m_count   = '0;
    logic        m_known   = 1'b0;
    logic        m_zero    = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, req, $time);
        end
    endtask

    function automatic logic [32:0] ref_result(input ins_t i);
        logic [31:0] b;
        logic [31:0] h;
        if (i.sel == 2'd2) return {1'b0, i.pc};
        if (i.sel != 2'd1) return {1'b0, i.alu};
        b = (i.mem >> (8 * i.lsb)) & 32'hFF;
        h = (i.mem >> (16 * (i.lsb / 2))) & 32'hFFFF;
        case (i.f3)
            3'd0: return {1'b0, (b < 128) ? b : b - 32'd256};
            3'd4: return {1'b0, b};
            3'd1: if (i.lsb % 2 != 0) return {1'b1, 32'd0};
                  else return {1'b0, (h < 32768) ? h : h - 32'd65536};
            3'd5: if (i.lsb % 2 != 0) return {1'b1, 32'd0};
                  else return {1'b0, h};
            3'd2: if (i.lsb != 0) return {1'b1, 32'd0};
                  else return {1'b0, i.mem};
            default: return {1'b1, 32'd0};
        endcase
    endfunction

    function automatic ins_t mk(input logic rw, input logic [4:0] rd, input logic [1:0] sel,
                                input logic [31:0] alu, input logic [31:0] memd,
                                input logic [2:0] f3, input logic [1:0] lsb);
        ins_t i;
        i.rw = rw; i.rd = rd; i.sel = sel; i.alu = alu; i.mem = memd;
        i.pc = alu + 32'd4; i.f3 = f3; i.lsb = lsb;
        return i;
    endfunction

    function automatic ins_t rnd_ins();
        ins_t i;
        i.rw = 1'($urandom_range(0, 1)); i.rd = 5'($urandom_range(0, 31));
        i.sel = 2'($urandom_range(0, 3)); i.alu = $urandom; i.mem = $urandom;
        i.pc = $urandom; i.f3 = 3'($urandom_range(0, 7)); i.lsb = 2'($urandom_range(0, 3));
        return i;
    endfunction

    // Drive one cycle, publish this cycle's expected outputs, then advance the model at the edge.
    task automatic step(input logic r, input logic v, input logic h, input logic f, input ins_t i);
        exp_t e;
        logic retire;
        logic [32:0] res;
        rst = r; hold = h; flush = f;
        bus.in_valid = v; bus.in_reg_write = i.rw; bus.in_rd = i.rd; bus.in_wb_sel = i.sel;
        bus.in_alu_result = i.alu; bus.in_mem_rdata = i.mem; bus.in_pc_plus4 = i.pc;
        bus.in_funct3 = i.f3; bus.in_addr_lsb = i.lsb;
        retire    = !r && m_present && !h && !f;
        e.en      = retire && m_rw && (m_rd != 0) && !m_err;
        e.lerr    = retire && m_err;
        e.ready   = !h;
        e.chk_cnt = m_known;
        e.cnt     = m_count;
        e.chk_dd  = m_zero || e.en;
        e.dest    = m_rd;
        e.data    = m_data;
        exp_q.push_back(e);
        @(posedge clk);
        if (r) begin
            m_present = 0; m_err = 0; m_rw = 0; m_rd = 0; m_data = 0;
            m_count = 0; m_known = 1; m_zero = 1;
        end else begin
            if (retire) m_count = m_count + 32'd1;
            if (f) m_present = 0;
            else if (!h) begin
                m_present = v;
                if (v) begin
                    res = ref_result(i);
                    m_err = res[32]; m_data = res[31:0]; m_rd = i.rd; m_rw = i.rw; m_zero = 0;
                end
            end
        end
        #1;
    endtask

    always @(negedge clk) begin
        exp_t e;
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            check("rg_wrt_en", 32'(rg_wrt_en), 32'(e.en));
            check("load_err", 32'(load_err), 32'(e.lerr));
            check("in_ready", 32'(bus.in_ready), 32'(e.ready));
            if (e.chk_cnt) check("retire_count", retire_count, e.cnt);
            if (e.chk_dd) begin
                check("rg_wrt_dest", 32'(rg_wrt_dest), 32'(e.dest));
                check("rg_wrt_data", rg_wrt_data, e.data);
            end
        end
    end

    initial begin
        ins_t nop;
        int   budget;
        nop = mk(0, 0, 0, 0, 0, 0, 0);
        rst = 1; hold = 0; flush = 0; bus.in_valid = 0;
        @(posedge clk); #1;
        step(1, 0, 0, 0, nop);
        step(1, 0, 0, 0, nop);
        step(0, 0, 0, 0, nop);
        // ALU writeback to x5
        step(0, 1, 0, 0, mk(1, 5, 2'b00, 32'h0000_1234, 0, 0, 0));
        step(0, 0, 0, 0, nop);
        // LB / LBU / LHU back to back
        step(0, 1, 0, 0, mk(1, 1, 2'b01, 0, 32'h80FF_7F01, 3'b000, 2'd3));
        step(0, 1, 0, 0, mk(1, 2, 2'b01, 0, 32'h80FF_7F01, 3'b100, 2'd3));
        step(0, 1, 0, 0, mk(1, 3, 2'b01, 0, 32'h80FF_7F01, 3'b101, 2'd2));
        step(0, 1, 0, 0, mk(1, 9, 2'b10, 32'h0000_0100, 0, 0, 0));
        step(0, 0, 0, 0, nop);
        // misaligned LW, then rd=0 write
        step(0, 1, 0, 0, mk(1, 7, 2'b01, 0, 32'hDEAD_BEEF, 3'b010, 2'd1));
        step(0, 1, 0, 0, mk(1, 0, 2'b00, 32'h5555_AAAA, 0, 0, 0));
        step(0, 0, 0, 0, nop);
        // hold for 3 cycles then release; then flush during hold
        step(0, 1, 0, 0, mk(1, 3, 2'b00, 32'h0000_0333, 0, 0, 0));
        repeat (3) step(0, 1, 1, 0, mk(1, 4, 2'b00, 32'h4444_4444, 0, 0, 0));
        step(0, 0, 0, 0, nop);
        step(0, 1, 0, 0, mk(1, 3, 2'b00, 32'h0000_0777, 0, 0, 0));
        step(0, 0, 1, 0, nop);
        step(0, 1, 1, 1, mk(1, 6, 2'b00, 32'h6666_6666, 0, 0, 0));
        step(0, 0, 0, 0, nop);
        step(0, 0, 0, 0, nop);
        // counter wrap from 0xFFFF_FFFF
        force dut.count_q = 32'hFFFF_FFFF;
        #1;
        release dut.count_q;
        m_count = 32'hFFFF_FFFF;
        step(0, 1, 0, 0, mk(1, 4, 2'b00, 32'h0000_0044, 0, 0, 0));
        step(0, 1, 0, 0, mk(1, 8, 2'b00, 32'h0000_0088, 0, 0, 0));
        step(0, 0, 0, 0, nop);
        // reset while an entry is held
        step(0, 1, 0, 0, mk(1, 10, 2'b00, 32'hAAAA_0000, 0, 0, 0));
        step(0, 0, 1, 0, nop);
        step(1, 0, 1, 0, nop);
        step(0, 0, 0, 0, nop);
        step(0, 0, 0, 0, nop);
        // randomized traffic
        for (int n = 0; n < 800; n++) begin
            step(($urandom_range(0, 99) == 0), ($urandom_range(0, 3) != 0),
                 ($urandom_range(0, 4) == 0), ($urandom_range(0, 7) == 0), rnd_ins());
        end
        step(0, 0, 0, 0, nop);
        step(0, 0, 0, 0, nop);
        budget = 20;
        while (exp_q.size() > 0 && budget > 0) begin
            @(negedge clk);
            budget--;
        end
        #1;
        check("scoreboard_drain", 32'(exp_q.size()), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/wb_stage.md
WB_STAGE -- requirements
Module: wb_stage

Interface
REQ-001 Parameter DATA_WIDTH, default 32, register/data width in bits.
REQ-002 Parameter ADDRESS_WIDTH, default 5, register address width.
REQ-003 clk  input  1  clock; all state updates on posedge.
REQ-004 rst  input  1  reset, synchronous, active-high.
REQ-005 in_valid  input  1  MEM stage presents a valid instruction.
REQ-006 in_ready  output  1  stage accepts input this cycle; equals !hold.
REQ-007 hold  input  1  freeze stage contents; no retirement.
REQ-008 flush  input  1  kill the captured entry.
REQ-009 in_reg_write  input  1  instruction writes rd.
REQ-010 in_rd  input  ADDRESS_WIDTH  destination register.
REQ-011 in_wb_sel  input  2  00 ALU, 01 load, 10 PC+4, 11 reserved (treated as ALU).
REQ-012 in_alu_result, in_mem_rdata, in_pc_plus4  input  DATA_WIDTH each  result sources.
REQ-013 in_funct3  input  3  load type; in_addr_lsb  input  2  load byte offset.
REQ-014 rg_wrt_en  output  1  register file write strobe.
REQ-015 rg_wrt_dest  output  ADDRESS_WIDTH  register file write address.
REQ-016 rg_wrt_data  output  DATA_WIDTH  register file write data.
REQ-017 load_err  output  1  one-cycle pulse: misaligned/illegal load retired.
REQ-018 retire_count  output  32  count of retired entries.

Function
REQ-019 One-entry pipeline register (valid, rd, reg_write, err, data); capture on posedge when in_valid && !hold && !flush; latency 1 cycle.
REQ-020 Result computed at capture: wb_sel 00/11 -> in_alu_result, 10 -> in_pc_plus4, 01 -> aligned load data.
REQ-021 Load alignment: funct3 000 LB byte[addr_lsb] sign-extended; 100 LBU zero-extended; 001 LH half[addr_lsb[1]] sign-extended; 101 LHU zero-extended; 010 LW full word.
REQ-022 Load error: LH/LHU with addr_lsb[0]=1, LW with addr_lsb!=0, or funct3 in {011,110,111}; err captured, data forced to 0.
REQ-023 Entry retires in any cycle with valid=1 && hold=0 && flush=0.
REQ-024 rg_wrt_en = retiring && reg_write && rd!=0 && !err; rg_wrt_dest/rg_wrt_data driven from stage register.
REQ-025 load_err = retiring && err; no register write in that cycle.
REQ-026 retire_count increments by 1 per retirement (including err and rd=0); wraps 0xFFFFFFFF -> 0.
REQ-027 hold=1: stage contents unchanged, rg_wrt_en=0, load_err=0, no new capture, in_ready=0.
REQ-028 flush=1: valid cleared on next posedge, no capture, no retirement this cycle; flush has priority over hold and in_valid.
REQ-029 in_valid=0 with hold=0: valid cleared on next posedge after retirement (bubble).
REQ-030 Back-to-back: retirement of entry N and capture of entry N+1 occur in the same cycle.
REQ-031 Write occurs in the cycle the entry sits in the stage, before the register file's falling-edge update; a read of rd in the following cycle returns the new value.

Reset
REQ-032 rst=1 at posedge: valid=0, err=0, retire_count=0; rst has priority over flush, hold, capture.
REQ-033 During and after reset, rg_wrt_en=0 and load_err=0 until a new entry is captured; rg_wrt_dest/rg_wrt_data reset to 0.
REQ-034 Reset mid-hold discards the held entry without writing it.

Verification
REQ-035 ALU: in_wb_sel=00, rd=5, alu=0x0000_1234 -> next cycle rg_wrt_en=1, dest=5, data=0x0000_1234, retire_count=1.
REQ-036 LB: mem_rdata=0x80FF_7F01, addr_lsb=3 -> data=0xFFFF_FF80; LBU same -> 0x0000_0080; LHU addr_lsb=2 -> 0x0000_80FF.
REQ-037 Misaligned LW addr_lsb=1, rd=7 -> rg_wrt_en=0, load_err=1 one cycle, retire_count increments.
REQ-038 rd=0, reg_write=1 -> rg_wrt_en=0, retire_count increments; register x0 unchanged.
REQ-039 Capture rd=3, hold=1 for 3 cycles -> no write, in_ready=0; hold release -> single write to x3; flush during hold -> no write, count unchanged.
REQ-040 retire_count preloaded near wrap (0xFFFF_FFFF via 2^32-1 retirements or forced) -> next retirement gives 0; rst mid-stream -> count 0, valid 0.
